// File: rtl/rgb_pll_supervisor_if.sv
// rgb_pll_supervisor_if
//   Bundles the supervisor's control, PLL and status signals so that the
//   supervisor and its surroundings connect with a single port.
//
//   Signals:
//     enable        supervisor enable; low forces IDLE
//     relock_req    single-cycle request for a fresh PLL reset sequence
//     pll_locked    PLL LOCK output, asynchronous to the reference clock
//     pll_resetb    PLL RESETB drive (active low)
//     sys_rst_n     active-low datapath reset
//     fail          high while the supervisor has given up
//     state         current supervisor state code
//     retry_cnt     timeouts in the current attempt sequence
//     lock_loss_cnt saturating count of lock losses seen while running
//
//   Modports:
//     master  the supervisor itself
//     slave   the system / PLL side
interface rgb_pll_supervisor_if #(
    parameter int MAX_RETRIES = 3
);
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

    logic               enable;
    logic               relock_req;
    logic               pll_locked;
    logic               pll_resetb;
    logic               sys_rst_n;
    logic               fail;
    logic [2:0]         state;
    logic [RETRY_W-1:0] retry_cnt;
    logic [7:0]         lock_loss_cnt;

    modport master (
        input  enable,
        input  relock_req,
        input  pll_locked,
        output pll_resetb,
        output sys_rst_n,
        output fail,
        output state,
        output retry_cnt,
        output lock_loss_cnt
    );

    modport slave (
        output enable,
        output relock_req,
        output pll_locked,
        input  pll_resetb,
        input  sys_rst_n,
        input  fail,
        input  state,
        input  retry_cnt,
        input  lock_loss_cnt
    );
endinterface

// File: rtl/rgb_pll_supervisor.sv
// rgb_pll_supervisor
//   Sequences the 96 MHz PLL from the 12 MHz reference clock: pulses
//   RESETB, waits for LOCK, requires LOCK to stay high for a run of
//   consecutive cycles, then releases the datapath reset. Lock loss while
//   running re-arms the PLL; repeated timeouts end in FAIL until a relock
//   request or enable drop.
//
//   Ports:
//     clk    12 MHz reference clock (keeps running when the PLL is dead)
//     rst_n  asynchronous active-low reset
//     bus    rgb_pll_supervisor_if.master (control inputs, PLL drive,
//            datapath reset and status outputs, all registered)
module rgb_pll_supervisor #(
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int RESET_PULSE_CYCLES  = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 120000,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    rgb_pll_supervisor_if.master        bus
);

    localparam int PULSE_W = $clog2(RESET_PULSE_CYCLES + 1) + 1;
    localparam int STAB_W  = $clog2(LOCK_STABLE_CYCLES + 1) + 1;
    localparam int TMO_W   = $clog2(LOCK_TIMEOUT_CYCLES + 1) + 1;
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(RESET_PULSE_CYCLES - 1);
    localparam logic [STAB_W-1:0]  STAB_DONE  = STAB_W'(LOCK_STABLE_CYCLES);
    localparam logic [TMO_W-1:0]   TMO_DONE   = TMO_W'(LOCK_TIMEOUT_CYCLES);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PLL_RST   = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_STABLE    = 3'd3,
        S_RUN       = 3'd4,
        S_FAIL      = 3'd5
    } state_t;

    state_t               state_q;
    logic                 lock_m;
    logic                 lock_s;
    logic                 pll_resetb_q;
    logic                 sys_rst_n_q;
    logic                 fail_q;
    logic [RETRY_W-1:0]   retry_q;
    logic [7:0]           loss_q;
    logic [PULSE_W-1:0]   pulse_q;
    logic [STAB_W-1:0]    stab_q;
    logic [TMO_W-1:0]     tmo_q;

    logic [STAB_W-1:0]    stab_nx;
    logic [TMO_W-1:0]     tmo_nx;
    logic                 relock_ok;

    assign stab_nx   = stab_q + 1'b1;
    assign tmo_nx    = tmo_q + 1'b1;
    assign relock_ok = bus.relock_req &&
                       (state_q inside {S_PLL_RST, S_WAIT_LOCK, S_STABLE, S_RUN, S_FAIL});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            lock_m       <= 1'b0;
            lock_s       <= 1'b0;
            pll_resetb_q <= 1'b0;
            sys_rst_n_q  <= 1'b0;
            fail_q       <= 1'b0;
            retry_q      <= '0;
            loss_q       <= '0;
            pulse_q      <= '0;
            stab_q       <= '0;
            tmo_q        <= '0;
        end else begin
            lock_m <= bus.pll_locked;
            lock_s <= lock_m;

            if (!bus.enable) begin
                state_q      <= S_IDLE;
                pll_resetb_q <= 1'b0;
                sys_rst_n_q  <= 1'b0;
                fail_q       <= 1'b0;
            end else if (relock_ok) begin
                state_q      <= S_PLL_RST;
                pll_resetb_q <= 1'b0;
                sys_rst_n_q  <= 1'b0;
                fail_q       <= 1'b0;
                retry_q      <= '0;
                pulse_q      <= '0;
                stab_q       <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        state_q <= S_PLL_RST;
                        retry_q <= '0;
                        pulse_q <= '0;
                    end

                    S_PLL_RST: begin
                        if (pulse_q == PULSE_LAST) begin
                            state_q      <= S_WAIT_LOCK;
                            pll_resetb_q <= 1'b1;
                            tmo_q        <= '0;
                            stab_q       <= '0;
                        end else begin
                            pulse_q <= pulse_q + 1'b1;
                        end
                    end

                    // WAIT_LOCK and STABLE share the timeout counter so that
                    // chatter between them cannot extend the lock budget.
                    S_WAIT_LOCK, S_STABLE: begin
                        if (state_q == S_STABLE && lock_s && stab_nx == STAB_DONE) begin
                            state_q     <= S_RUN;
                            sys_rst_n_q <= 1'b1;
                            retry_q     <= '0;
                        end else if (tmo_nx == TMO_DONE) begin
                            stab_q       <= '0;
                            pll_resetb_q <= 1'b0;
                            if (retry_q < RETRY_MAX) begin
                                state_q <= S_PLL_RST;
                                retry_q <= retry_q + 1'b1;
                                pulse_q <= '0;
                            end else begin
                                state_q <= S_FAIL;
                                fail_q  <= 1'b1;
                            end
                        end else begin
                            tmo_q <= tmo_nx;
                            if (lock_s) begin
                                state_q <= S_STABLE;
                                stab_q  <= (state_q == S_WAIT_LOCK) ? STAB_W'(1) : stab_nx;
                            end else begin
                                state_q <= S_WAIT_LOCK;
                                stab_q  <= '0;
                            end
                        end
                    end

                    S_RUN: begin
                        retry_q <= '0;
                        if (!lock_s) begin
                            state_q      <= S_PLL_RST;
                            pll_resetb_q <= 1'b0;
                            sys_rst_n_q  <= 1'b0;
                            pulse_q      <= '0;
                            if (loss_q != '1) begin
                                loss_q <= loss_q + 1'b1;
                            end
                        end
                    end

                    S_FAIL: begin
                        pll_resetb_q <= 1'b0;
                        sys_rst_n_q  <= 1'b0;
                        fail_q       <= 1'b1;
                    end

                    default: begin
                        state_q      <= S_IDLE;
                        pll_resetb_q <= 1'b0;
                        sys_rst_n_q  <= 1'b0;
                        fail_q       <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.state         = state_q;
    assign bus.pll_resetb    = pll_resetb_q;
    assign bus.sys_rst_n     = sys_rst_n_q;
    assign bus.fail          = fail_q;
    assign bus.retry_cnt     = retry_q;
    assign bus.lock_loss_cnt = loss_q;

endmodule
